joypad_poll_ctrl: RTL
=====================

# joypad_poll_ctrl

Sequences one NES standard-controller read: latch pulse, seven clock pulses, eight serial bit samples. Assembles the result into a parallel button byte for the rest of the SOC. The pad-side signals pass through the board's inverting buffers, so this block drives and samples them in the active-low/active-high senses given below. It sits between the controller-port pins and the CPU-visible input register, and is triggered once per frame, typically by vblank.

## Interface
- CLK_DIV, 6: half-period of the pad clock and width of the latch pulse, in clk cycles; legal range 4..255.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle poll request; honoured only when busy=0.
- pad_data_n  in  1  serial pad data, active-low (0 = button pressed); asynchronous to clk.
- pad_latch  out  1  latch/strobe to pad, active-high; registered.
- pad_clk_n  out  1  pad shift clock, idle high, active-low pulse; registered.
- busy  out  1  high while a poll is in progress.
- btn  out  8  last completed poll, 1 = pressed; bit order [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- btn_vld  out  1  one-cycle pulse when btn is updated.

## Operation
- pad_data_n passes through a 2-flop synchronizer, reset value 1 (released). All samples use the synchronizer output. Sampled bit = ~sync.
- The FSM states are IDLE, LATCH, WAIT0, CLK_LO, CLK_HI, DONE. A down-counter, cnt, is loaded with CLK_DIV-1 on each state entry. A 3-bit bit index, idx, counts 1..7.
- IDLE: pad_latch=0, pad_clk_n=1, busy=0. If start=1, go to LATCH.
- LATCH: pad_latch=1 for CLK_DIV cycles, then go to WAIT0.
- WAIT0: pad_latch=0 for CLK_DIV cycles. On the last cycle, shift[0] <= sampled bit and idx <= 1. Then go to CLK_LO.
- CLK_LO: pad_clk_n=0 for CLK_DIV cycles, then go to CLK_HI.
- CLK_HI: pad_clk_n=1 for CLK_DIV cycles. On the last cycle, shift[idx] <= sampled bit.
  - If idx=7, go to DONE.
  - Otherwise idx <= idx+1 and go to CLK_LO.
- DONE: one cycle; btn <= shift, btn_vld=1, then go to IDLE.
- start while busy=1 is ignored. Requests are neither queued nor counted.
- btn holds its value between polls. A partial poll never changes btn.

## Timing
- Edge 0 is the rising edge at which start=1 is sampled in IDLE.
- busy=1 and pad_latch=1 are visible from edge 0. pad_latch returns to 0 at edge CLK_DIV.
- Bit 0 is sampled at edge 2·CLK_DIV.
- Pad clock pulse i (i=1..7):
  - pad_clk_n=0 from edge 2·CLK_DIV·i to edge 2·CLK_DIV·i + CLK_DIV.
  - Bit i is sampled at edge 2·CLK_DIV·(i+1).
- Bit 7 is sampled at edge 16·CLK_DIV.
- DONE runs from edge 16·CLK_DIV to edge 16·CLK_DIV+1: btn and btn_vld become visible during this cycle, and btn_vld=1 for exactly one cycle.
- At edge 16·CLK_DIV+1: busy=0 and the FSM is in IDLE.
  - A start sampled at edge 16·CLK_DIV+1 begins a new poll.
  - A start during DONE is ignored.
- Poll latency, start to btn_vld: 16·CLK_DIV cycles. Minimum repeat interval: 16·CLK_DIV+1 cycles.
- Synchronizer delay is 2 cycles. The sampling point is at least CLK_DIV-2 ≥ 2 cycles after the preceding pad edge.
- Reset values: pad_latch=0, pad_clk_n=1, busy=0, btn=8'h00, btn_vld=0, FSM=IDLE, shift=0, idx=0, synchronizer=2'b11.
- Reset asserted mid-poll forces all reset values immediately (asynchronous). The poll is abandoned, btn reads 8'h00, and no btn_vld is produced. After rst_n rises, the first start is accepted normally.

## Test plan
- Basic poll, CLK_DIV=6: the pad model drives the bit sequence for A, Start, Down, Right pressed, i.e. pad_data_n low at bit times 0, 3, 5, 7 → btn=8'hA9 with btn_vld at edge 96. Check pad_latch high for exactly 6 cycles, exactly 7 pad_clk_n low pulses each 6 cycles long, and busy low from edge 97.
- All released: pad_data_n held 1 → btn=8'h00, one btn_vld. Then all pressed (pad_data_n held 0) on the next poll → btn=8'hFF.
- start pulses at edges 1, 50 and 96 of an active poll → single btn_vld; no extra latch pulse. A start at edge 97 launches a new pad_latch at that edge.
- rst_n low at edge 40 of a poll whose previous result was 8'h3C → outputs at reset values asynchronously, btn=8'h00, no btn_vld. A subsequent start completes a normal poll.
- pad_data_n toggles within 1 cycle of a CLK_LO entry but is stable 3 cycles before each sample → captured byte matches the stable values.
- CLK_DIV=4 (minimum) with the pattern 8'h5A → btn=8'h5A at edge 64, with pad_clk_n high and low phases each 4 cycles.

Source files
------------

// File: rtl/joypad_poll_ctrl.sv
// NES controller poll sequencer: latch, seven pad clocks, eight samples.
// Produces a parallel button byte (1 = pressed) once per poll.
`timescale 1ns/1ps
module joypad_poll_ctrl #(
   parameter int CLK_DIV = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pad_data_n,
   output logic       pad_latch,
   output logic       pad_clk_n,
   output logic       busy,
   output logic [7:0] btn,
   output logic       btn_vld
);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      WAIT0,
      CLK_LO,
      CLK_HI,
      DONE
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(CLK_DIV - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift;
   logic [1:0] sync;
   logic       last;
   logic       bit_s;
   logic       latch_nxt;
   logic       clk_n_nxt;
   logic       busy_nxt;
   logic       vld_nxt;

   assign last  = (cnt == 8'd0);
   assign bit_s = ~sync[1];

   // State register and registered pad/handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pad_latch <= 1'b0;
         pad_clk_n <= 1'b1;
         busy      <= 1'b0;
         btn_vld   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pad_latch <= latch_nxt;
         pad_clk_n <= clk_n_nxt;
         busy      <= busy_nxt;
         btn_vld   <= vld_nxt;
      end
   end

   // Next-state: every timed phase lasts until the down-counter hits zero
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (start) state_nxt = LATCH;
         LATCH:  if (last) state_nxt = WAIT0;
         WAIT0:  if (last) state_nxt = CLK_LO;
         CLK_LO: if (last) state_nxt = CLK_HI;
         CLK_HI: if (last) state_nxt = (idx == 3'd7) ? DONE : CLK_LO;
         DONE:   state_nxt = start ? LATCH : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they align with state entry
   always_comb begin
      latch_nxt = (state_nxt == LATCH);
      clk_n_nxt = (state_nxt != CLK_LO);
      busy_nxt  = (state_nxt != IDLE);
      vld_nxt   = (state_nxt == DONE);
   end

   // Two-flop synchronizer; idles released (high) out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], pad_data_n};
   end

   // Phase timer reloads on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 8'd0;
      end else if (state_nxt != state) begin
         cnt <= CNT_LOAD;
      end else if (!last) begin
         cnt <= cnt - 8'd1;
      end
   end

   // Bit capture at the end of WAIT0 and each CLK_HI phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift <= 8'h00;
         idx   <= 3'd0;
      end else if (state == WAIT0 && last) begin
         shift[0] <= bit_s;
         idx      <= 3'd1;
      end else if (state == CLK_HI && last) begin
         shift[idx] <= bit_s;
         if (idx != 3'd7) idx <= idx + 3'd1;
      end
   end

   // Result byte publishes with bit 7 folded in so it is valid during DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn <= 8'h00;
      end else if (state == CLK_HI && last && idx == 3'd7) begin
         btn <= {bit_s, shift[6:0]};
      end
   end

endmodule
